// File: rtl/txn_pkg.sv
// rtl/txn_pkg.sv - shared state, process and status encodings for the transaction sequencer
package txn_pkg;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_FETCH       = 4'd1,
        S_LD_REG      = 4'd2,
        S_WAIT_PLAYER = 4'd3,
        S_LD_PLAYER   = 4'd4,
        S_WAIT_AMOUNT = 4'd5,
        S_LD_AMOUNT   = 4'd6,
        S_CHK_AMOUNT  = 4'd7,
        S_WAIT_KEY    = 4'd8,
        S_LD_KEY      = 4'd9,
        S_CHK_KEY     = 4'd10,
        S_COMMIT      = 4'd11,
        S_DONE        = 4'd12,
        S_REJECT      = 4'd13
    } state_e;

    localparam logic [2:0] PROC_IDLE   = 3'b000;
    localparam logic [2:0] PROC_AMOUNT = 3'b001;
    localparam logic [2:0] PROC_KEY    = 3'b010;
    localparam logic [2:0] PROC_COMMIT = 3'b011;

    localparam logic [1:0] STATUS_NONE       = 2'b00;
    localparam logic [1:0] STATUS_ACCEPTED   = 2'b01;
    localparam logic [1:0] STATUS_AMOUNT_REJ = 2'b10;
    localparam logic [1:0] STATUS_KEY_REJ    = 2'b11;

    function automatic logic state_busy(input state_e s);
        return !(s inside {S_IDLE, S_DONE, S_REJECT});
    endfunction

    function automatic logic [2:0] state_process(input state_e s);
        case (s)
            S_CHK_AMOUNT: return PROC_AMOUNT;
            S_CHK_KEY:    return PROC_KEY;
            S_COMMIT:     return PROC_COMMIT;
            default:      return PROC_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector; held sample resets high so a level held through reset never fires
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_d;
    logic sig_q;

    always_comb begin
        sig_d = sig;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/transaction_control.sv
// rtl/transaction_control.sv - sequencing FSM driving the transaction datapath: fetch, collect inputs, verify, commit
module transaction_control
    import txn_pkg::*;
#(
    parameter int MEM_LATENCY    = 1,
    parameter int AMOUNT_TIMEOUT = 16,
    parameter int KEY_TIMEOUT    = 255,
    parameter int KEY_ATTEMPTS   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       cancel,
    input  logic       done_step,
    output logic       mem_read,
    output logic       load_register,
    output logic       load_player,
    output logic       load_amount,
    output logic       load_key,
    output logic [2:0] process,
    output logic       mem_write,
    output logic       busy,
    output logic [1:0] status,
    output logic [3:0] state_dbg
);

    localparam int CNT_MAX_AK = (AMOUNT_TIMEOUT > KEY_TIMEOUT) ? AMOUNT_TIMEOUT : KEY_TIMEOUT;
    localparam int CNT_MAX    = (CNT_MAX_AK > MEM_LATENCY) ? CNT_MAX_AK : MEM_LATENCY;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int ATT_W      = $clog2(KEY_ATTEMPTS + 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [ATT_W-1:0] attempts_d, attempts_q;
    logic [1:0]       status_d, status_q;
    logic             mem_read_d, mem_read_q;
    logic             load_register_d, load_register_q;
    logic             load_player_d, load_player_q;
    logic             load_amount_d, load_amount_q;
    logic             load_key_d, load_key_q;
    logic             mem_write_d, mem_write_q;
    logic             busy_d, busy_q;
    logic [2:0]       process_d, process_q;
    logic             go_edge;

    edge_detect u_go_edge (
        .clock (clock),
        .reset (reset),
        .sig   (go),
        .rise  (go_edge)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        attempts_d = attempts_q;
        status_d   = status_q;

        if (cancel && state_busy(state_q) && (state_q != S_COMMIT)) begin
            state_d  = S_IDLE;
            status_d = STATUS_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_REJECT: begin
                    if (go_edge) begin
                        state_d    = S_FETCH;
                        status_d   = STATUS_NONE;
                        attempts_d = '0;
                    end
                end
                S_FETCH: begin
                    if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                        state_d = S_LD_REG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_LD_REG:      state_d = S_WAIT_PLAYER;
                S_WAIT_PLAYER: if (go_edge) state_d = S_LD_PLAYER;
                S_LD_PLAYER:   state_d = S_WAIT_AMOUNT;
                S_WAIT_AMOUNT: if (go_edge) state_d = S_LD_AMOUNT;
                S_LD_AMOUNT:   state_d = S_CHK_AMOUNT;
                // done_step in the entry cycle still reflects the previous process code
                S_CHK_AMOUNT: begin
                    if ((cnt_q != '0) && done_step) begin
                        state_d = S_WAIT_KEY;
                    end else if (cnt_q == CNT_W'(AMOUNT_TIMEOUT - 1)) begin
                        state_d  = S_REJECT;
                        status_d = STATUS_AMOUNT_REJ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_KEY: if (go_edge) state_d = S_LD_KEY;
                S_LD_KEY:   state_d = S_CHK_KEY;
                S_CHK_KEY: begin
                    if ((cnt_q != '0) && done_step) begin
                        state_d = S_COMMIT;
                    end else if (cnt_q == CNT_W'(KEY_TIMEOUT - 1)) begin
                        attempts_d = attempts_q + ATT_W'(1);
                        if (attempts_d < ATT_W'(KEY_ATTEMPTS)) begin
                            state_d = S_WAIT_KEY;
                        end else begin
                            state_d  = S_REJECT;
                            status_d = STATUS_KEY_REJ;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    state_d  = S_DONE;
                    status_d = STATUS_ACCEPTED;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // outputs are decoded from the next state so they are registered yet valid on entry
        mem_read_d      = (state_d == S_FETCH) && (state_q != S_FETCH);
        load_register_d = (state_d == S_LD_REG);
        load_player_d   = (state_d == S_LD_PLAYER);
        load_amount_d   = (state_d == S_LD_AMOUNT);
        load_key_d      = (state_d == S_LD_KEY);
        mem_write_d     = (state_d == S_COMMIT);
        busy_d          = state_busy(state_d);
        process_d       = state_process(state_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            attempts_q      <= '0;
            status_q        <= STATUS_NONE;
            mem_read_q      <= 1'b0;
            load_register_q <= 1'b0;
            load_player_q   <= 1'b0;
            load_amount_q   <= 1'b0;
            load_key_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            busy_q          <= 1'b0;
            process_q       <= PROC_IDLE;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            attempts_q      <= attempts_d;
            status_q        <= status_d;
            mem_read_q      <= mem_read_d;
            load_register_q <= load_register_d;
            load_player_q   <= load_player_d;
            load_amount_q   <= load_amount_d;
            load_key_q      <= load_key_d;
            mem_write_q     <= mem_write_d;
            busy_q          <= busy_d;
            process_q       <= process_d;
        end
    end

    assign mem_read      = mem_read_q;
    assign load_register = load_register_q;
    assign load_player   = load_player_q;
    assign load_amount   = load_amount_q;
    assign load_key      = load_key_q;
    assign mem_write     = mem_write_q;
    assign busy          = busy_q;
    assign process       = process_q;
    assign status        = status_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_transaction_control.sv
// tb/tb_transaction_control.sv - scoreboard bench for transaction_control with a transaction-level reference model
module tb_transaction_control;
    import txn_pkg::*;

    localparam int ML = 1;
    localparam int AT = 16;
    localparam int KT = 8;
    localparam int KA = 3;

    localparam int EV_MEM_READ    = 0;
    localparam int EV_LOAD_REG    = 1;
    localparam int EV_LOAD_PLAYER = 2;
    localparam int EV_LOAD_AMOUNT = 3;
    localparam int EV_LOAD_KEY    = 4;
    localparam int EV_MEM_WRITE   = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       cancel = 1'b0;
    logic       done_step = 1'b0;
    logic       mem_read, load_register, load_player, load_amount, load_key, mem_write, busy;
    logic [2:0] process_o;
    logic [1:0] status;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    transaction_control #(
        .MEM_LATENCY    (ML),
        .AMOUNT_TIMEOUT (AT),
        .KEY_TIMEOUT    (KT),
        .KEY_ATTEMPTS   (KA)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .go            (go),
        .cancel        (cancel),
        .done_step     (done_step),
        .mem_read      (mem_read),
        .load_register (load_register),
        .load_player   (load_player),
        .load_amount   (load_amount),
        .load_key      (load_key),
        .process       (process_o),
        .mem_write     (mem_write),
        .busy          (busy),
        .status        (status),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_pop(input int ev);
        int e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe: unexpected event %0d with empty queue at %0t", ev, $time);
        end else begin
            e = exp_q.pop_front();
            if (e != ev) begin
                errors++;
                $display("FAIL strobe: got event %0d expected %0d at %0t", ev, e, $time);
            end
        end
    endtask

    // monitor: every strobe pulse must match the next expected event
    always @(negedge clock) begin
        if (mem_read)      mon_pop(EV_MEM_READ);
        if (load_register) mon_pop(EV_LOAD_REG);
        if (load_player)   mon_pop(EV_LOAD_PLAYER);
        if (load_amount)   mon_pop(EV_LOAD_AMOUNT);
        if (load_key)      mon_pop(EV_LOAD_KEY);
        if (mem_write) begin
            mon_pop(EV_MEM_WRITE);
            check("commit_process", process_o, PROC_COMMIT);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic gap();
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic press_go();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
    endtask

    task automatic run_chk(input int k, input int t, input int code, input bit blank);
        for (int c = 0; c < t; c++) begin
            if (c == 0 || c == t - 1) check("chk_process", process_o, code);
            done_step = (c == k) || (blank && c == 0);
            tick();
            if (c == k && k >= 1) break;
        end
        done_step = 1'b0;
    endtask

    task automatic to_wait_amount();
        gap();
        press_go();
        gap();
        press_go();
        gap();
    endtask

    task automatic settle_queue(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // reference model: outcome follows from which cycle done_step arrives in each check window
    task automatic do_txn(input string name, input int amt_k, input bit blank, input int key_k[KA]);
        bit amt_ok;
        int exp_status;
        int keys_used;
        amt_ok     = (amt_k >= 1) && (amt_k < AT);
        keys_used  = 0;
        exp_status = STATUS_AMOUNT_REJ;
        if (amt_ok) begin
            exp_status = STATUS_KEY_REJ;
            for (int i = 0; i < KA; i++) begin
                keys_used++;
                if (key_k[i] >= 1 && key_k[i] < KT) begin
                    exp_status = STATUS_ACCEPTED;
                    break;
                end
            end
        end
        exp_q.push_back(EV_MEM_READ);
        exp_q.push_back(EV_LOAD_REG);
        exp_q.push_back(EV_LOAD_PLAYER);
        exp_q.push_back(EV_LOAD_AMOUNT);
        repeat (keys_used) exp_q.push_back(EV_LOAD_KEY);
        if (exp_status == STATUS_ACCEPTED) exp_q.push_back(EV_MEM_WRITE);

        to_wait_amount();
        press_go();
        run_chk(amt_k, AT, PROC_AMOUNT, blank);
        for (int i = 0; i < keys_used; i++) begin
            gap();
            press_go();
            run_chk(key_k[i], KT, PROC_KEY, 1'b0);
        end
        if (exp_status == STATUS_ACCEPTED) tick();
        check({name, "_status"}, status, exp_status);
        check({name, "_busy"}, busy, 0);
        check({name, "_state"}, state_dbg, (exp_status == STATUS_ACCEPTED) ? S_DONE : S_REJECT);
        settle_queue({name, "_events"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int kk[KA];

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_status", status, STATUS_NONE);
        check("rst_process", process_o, PROC_IDLE);
        check("rst_state", state_dbg, S_IDLE);
        check("rst_strobes", {mem_read, load_register, load_player, load_amount, load_key, mem_write}, 0);
        reset = 1'b0;
        tick();

        kk = '{2, 99, 99};
        do_txn("happy", 2, 1'b0, kk);
        kk = '{2, 2, 2};
        do_txn("amount_fail", 99, 1'b0, kk);
        kk = '{99, 99, 3};
        do_txn("key_retry", 2, 1'b0, kk);
        kk = '{99, 99, 99};
        do_txn("key_reject", 5, 1'b0, kk);
        kk = '{2, 2, 2};
        do_txn("blanking", 99, 1'b1, kk);
        kk = '{KT - 1, 99, 99};
        do_txn("edge_limits", AT - 1, 1'b0, kk);

        // cancel while verifying the key
        exp_q.push_back(EV_MEM_READ);
        exp_q.push_back(EV_LOAD_REG);
        exp_q.push_back(EV_LOAD_PLAYER);
        exp_q.push_back(EV_LOAD_AMOUNT);
        exp_q.push_back(EV_LOAD_KEY);
        to_wait_amount();
        press_go();
        run_chk(1, AT, PROC_AMOUNT, 1'b0);
        gap();
        press_go();
        tick();
        cancel = 1'b1;
        done_step = 1'b1;
        tick();
        cancel = 1'b0;
        done_step = 1'b0;
        check("cancel_key_busy", busy, 0);
        check("cancel_key_status", status, STATUS_NONE);
        check("cancel_key_state", state_dbg, S_IDLE);
        repeat (10) tick();
        settle_queue("cancel_key_events");

        // cancel and go edge together in WAIT_AMOUNT
        exp_q.push_back(EV_MEM_READ);
        exp_q.push_back(EV_LOAD_REG);
        exp_q.push_back(EV_LOAD_PLAYER);
        to_wait_amount();
        go = 1'b1;
        cancel = 1'b1;
        tick();
        go = 1'b0;
        cancel = 1'b0;
        check("cancel_go_state", state_dbg, S_IDLE);
        check("cancel_go_busy", busy, 0);
        repeat (4) tick();
        settle_queue("cancel_go_events");

        // go held high through reset must not start a transaction
        reset = 1'b1;
        go = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("go_held_busy", busy, 0);
        check("go_held_state", state_dbg, S_IDLE);
        go = 1'b0;
        tick();
        exp_q.push_back(EV_MEM_READ);
        exp_q.push_back(EV_LOAD_REG);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_rise_state", state_dbg, S_FETCH);
        check("go_rise_busy", busy, 1);
        repeat (2) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("go_rise_cancel_busy", busy, 0);
        settle_queue("go_held_events");

        // reset during COMMIT
        exp_q.push_back(EV_MEM_READ);
        exp_q.push_back(EV_LOAD_REG);
        exp_q.push_back(EV_LOAD_PLAYER);
        exp_q.push_back(EV_LOAD_AMOUNT);
        exp_q.push_back(EV_LOAD_KEY);
        exp_q.push_back(EV_MEM_WRITE);
        to_wait_amount();
        press_go();
        run_chk(2, AT, PROC_AMOUNT, 1'b0);
        gap();
        press_go();
        run_chk(2, KT, PROC_KEY, 1'b0);
        check("commit_state", state_dbg, S_COMMIT);
        reset = 1'b1;
        tick();
        check("rst_commit_outputs",
              {mem_read, load_register, load_player, load_amount, load_key, mem_write, busy, process_o, status}, 0);
        check("rst_commit_state", state_dbg, S_IDLE);
        reset = 1'b0;
        tick();
        settle_queue("rst_commit_events");

        // reset in the same cycle as a key accept: no write may follow
        exp_q.push_back(EV_MEM_READ);
        exp_q.push_back(EV_LOAD_REG);
        exp_q.push_back(EV_LOAD_PLAYER);
        exp_q.push_back(EV_LOAD_AMOUNT);
        exp_q.push_back(EV_LOAD_KEY);
        to_wait_amount();
        press_go();
        run_chk(3, AT, PROC_AMOUNT, 1'b0);
        gap();
        press_go();
        tick();
        done_step = 1'b1;
        reset = 1'b1;
        tick();
        done_step = 1'b0;
        reset = 1'b0;
        check("rst_chk_busy", busy, 0);
        repeat (6) tick();
        settle_queue("rst_chk_events");

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < KA; i++) kk[i] = $urandom_range(1, KT + 3);
            do_txn($sformatf("rand%0d", n), $urandom_range(1, AT + 3), 1'($urandom_range(0, 1)), kk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
